// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit Kogge-Stone digit per clock, LSB first, valid/ready in and out.
// Optional signed-overflow output `ovf` is enabled by defining DIGIT_SERIAL_OVF_EN.
module digit_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef DIGIT_SERIAL_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int DIGITS = WIDTH / 4;
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic [WIDTH-1:0] sum_sh_reg;
   logic             carry_reg;
   logic [CW-1:0]    cnt_reg;

   logic [3:0]       p, g, p1, g1, p2, g2, c;
   logic [3:0]       dsum;
   logic [WIDTH-1:0] sum_next;

   assign in_ready = (state_reg == IDLE) && !rst;

   assign p = a_sh_reg[3:0] ^ b_sh_reg[3:0];
   assign g = a_sh_reg[3:0] & b_sh_reg[3:0];

   // Two prefix levels (span 1, span 2) give group G/P for bits [i:0];
   // the registered carry then seeds every position.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_prefix
         if (gi >= 1) begin : g_l1
            assign g1[gi] = g[gi] | (p[gi] & g[gi-1]);
            assign p1[gi] = p[gi] & p[gi-1];
         end else begin : g_l1_pass
            assign g1[gi] = g[gi];
            assign p1[gi] = p[gi];
         end
         if (gi >= 2) begin : g_l2
            assign g2[gi] = g1[gi] | (p1[gi] & g1[gi-2]);
            assign p2[gi] = p1[gi] & p1[gi-2];
         end else begin : g_l2_pass
            assign g2[gi] = g1[gi];
            assign p2[gi] = p1[gi];
         end
         assign c[gi] = g2[gi] | (p2[gi] & carry_reg);
      end
   endgenerate

   assign dsum = p ^ {c[2:0], carry_reg};

   generate
      if (DIGITS == 1) begin : g_one_digit
         assign sum_next = dsum;
      end else begin : g_multi_digit
         assign sum_next = {dsum, sum_sh_reg[WIDTH-1:4]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         out_valid  <= 1'b0;
         sum        <= '0;
         cout       <= 1'b0;
         cnt_reg    <= '0;
         carry_reg  <= 1'b0;
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         sum_sh_reg <= '0;
`ifdef DIGIT_SERIAL_OVF_EN
         ovf        <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_sh_reg  <= a;
                  b_sh_reg  <= b;
                  carry_reg <= cin;
                  cnt_reg   <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               a_sh_reg   <= a_sh_reg >> 4;
               b_sh_reg   <= b_sh_reg >> 4;
               sum_sh_reg <= sum_next;
               carry_reg  <= c[3];
               cnt_reg    <= cnt_reg + 1'b1;
               if (cnt_reg == LAST) begin
                  sum       <= sum_next;
                  cout      <= c[3];
`ifdef DIGIT_SERIAL_OVF_EN
                  // c[2] is the carry into the MSB of the final digit
                  ovf       <= c[3] ^ c[2];
`endif
                  out_valid <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
